rv32i_decode_stage: RTL and testbench
=====================================

Name: rv32i_decode_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline: fetch, decode, execute, mem/branch, writeback.
- Takes the IF/ID instruction word and holds the 32x32 register file, written from writeback.
- Produces registered ID/EX operands, immediate and control signals that drive execute, mem/branch and writeback.
- Squashes its output to a bubble on a pipeline flush.

Parameters:
- RESET_INS, 32'h00000013, instruction treated as in flight after reset (ADDI x0,x0,0). Informational only; outputs reset to the NOP encoding below.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- pipe_flush  in  1  taken jump/branch; squash the instruction being decoded
- if_id__ins  in  32  instruction from fetch
- wb_id__rd_wen  in  1  register-file write enable
- wb_id__rd_addr  in  5  write address
- wb_id__rd_wdata  in  32  write data
- id_ex__rs1_rdata, id_ex__rs2_rdata  out  32  register operands
- id_ex__rs1_addr, id_ex__rs2_addr, id_ex__rd_addr  out  5  ins[19:15], ins[24:20], ins[11:7]
- id_ex__imm  out  32  sign-extended immediate
- id_ex__alu_op  out  4  ALU operation
- id_ex__alu_a_src  out  2  ALU A select
- id_ex__alu_b_src  out  1  ALU B select
- id_ex__dmem_width  out  2  memory width
- id_ex__dmem_zero_ext  out  1  load zero-extend (funct3[2])
- id_ex__dmem_read, id_ex__dmem_write  out  1  load / store
- id_ex__jump_base_src  out  1  jump base select
- id_ex__jump_cond  out  2  jump condition
- id_ex__rd_wen  out  1  destination write enable
- id_ex__rd_src  out  2  writeback data select

Behaviour:
- All id_ex__* outputs are registered. Latency is 1 cycle from if_id__ins to outputs, aligned with the ID/EX pc register.
- Reset (async):
  - all outputs 0, which is the NOP encoding: jump_cond NEVER, no writes, no memory access;
  - all 32 registers cleared to 0.
- Flush: pipe_flush=1 at a clock edge loads rd_wen=0, dmem_read=0, dmem_write=0, jump_cond=NEVER. Other fields are don't-care.
- Register file:
  - 32x32 array, written on the clock edge when wb_id__rd_wen=1 and rd_addr!=0;
  - x0 always reads 0;
  - same-cycle write-through: a read of the address being written returns wb_id__rd_wdata.
- rd_wen is forced to 0 when rd==0.
- Encodings:
  - alu_op: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
  - alu_a_src: RS1=0 PC=1 ZERO=2
  - alu_b_src: RS2=0 IMM=1
  - dmem_width: B=0 H=1 W=2
  - jump_cond: NEVER0 ALWAYS1 ZERO2 NZERO3
  - jump_base_src: PC=0 RS1=1
  - rd_src: ALU=0 PC4=1 DMEM=2
- Immediates (all sign-extended from ins[31]): I, S, B (bit0=0), U (low 12 zero), J (bit0=0).
- Per opcode:
  - OP (0110011): alu from funct3 and ins[30]; b=RS2; rd_wen; rd_src ALU.
  - OP-IMM (0010011): as OP with b=IMM and I-imm. ins[30] selects SRA only for funct3=101; ADDI never becomes SUB.
  - LUI: a=ZERO, b=IMM, ADD.
  - AUIPC: a=PC, b=IMM, ADD.
  - LOAD: ADD, rs1+I-imm; dmem_read; rd_src DMEM; width = funct3[1:0]; zero_ext = funct3[2].
  - STORE: ADD, rs1+S-imm; dmem_write; no rd_wen.
  - JAL: cond ALWAYS; base PC; J-imm; rd_src PC4.
  - JALR: cond ALWAYS; base RS1; I-imm; rd_src PC4.
  - BRANCH: b=RS2; B-imm; base PC; no rd_wen.
    - BEQ: SUB, ZERO. BNE: SUB, NZERO.
    - BLT: SLT, NZERO. BGE: SLT, ZERO.
    - BLTU: SLTU, NZERO. BGEU: SLTU, ZERO.
- Any other opcode (FENCE, SYSTEM, illegal): NOP encoding.
- Operand data is not forwarded here beyond the write-through; execute owns forwarding.

Decomposition:
- Shared package: opcode constants and the alu_op, alu_a_src, alu_b_src, dmem_width, jump_cond, jump_base_src and rd_src encodings. COND_NEVER is shared with mem/branch.
- One sub-module, rv32i_regfile (2 read / 1 write, x0 hard-zero, write-through, async reset). Control decode and immediate generation live in the stage.

Test Plan:
- ADDI x1,x0,5 (0x00500093) → next cycle: imm=5, rd_addr=1, alu_op=ADD, a=RS1, b=IMM, rd_wen=1, rd_src=ALU.
- LUI x2,0x12345 (0x12345137) → imm=0x12345000, a_src=ZERO, b=IMM, rd_wen=1.
- Writeback of x3=0xDEADBEEF in the same cycle as ADD x4,x3,x3 (0x00318233) → rs1_rdata=rs2_rdata=0xDEADBEEF. A write to x0 followed by a read of x0 → 0.
- BNE x1,x2,-8 (0xFE209CE3) → imm=0xFFFFFFF8, alu_op=SUB, jump_cond=NZERO, base=PC, rd_wen=0. LBU x5,3(x1) (0x0030C283) → dmem_read=1, width=B, zero_ext=1, rd_src=DMEM.
- SW x2,4(x1) with pipe_flush=1 at the edge → dmem_write=0, rd_wen=0, jump_cond=NEVER. JALR x1,0(x6) with rst asserted mid-cycle → outputs 0 immediately, with no clock.
- SRAI x7,x7,3 (0x4033D393) → alu_op=SRA, imm[4:0]=3. ADDI with ins[30]=1 → still ADD. Opcode 0x73 → NOP encoding.

Source files
------------

// File: rtl/rv32i_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, control-field encodings and the ID/EX control bundle.
// COND_NEVER is also consumed by the mem/branch stage.
package rv32i_decode_stage_pkg;

    localparam logic [31:0] RESET_INS = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
        ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_src_e;
    typedef enum logic       {B_RS2 = 1'b0, B_IMM = 1'b1} alu_b_src_e;
    typedef enum logic [1:0] {COND_NEVER = 2'd0, COND_ALWAYS = 2'd1, COND_ZERO = 2'd2, COND_NZERO = 2'd3} jump_cond_e;
    typedef enum logic       {BASE_PC = 1'b0, BASE_RS1 = 1'b1} jump_base_src_e;
    typedef enum logic [1:0] {RD_ALU = 2'd0, RD_PC4 = 2'd1, RD_DMEM = 2'd2} rd_src_e;

    typedef struct packed {
        logic [4:0]     rs1_addr;
        logic [4:0]     rs2_addr;
        logic [4:0]     rd_addr;
        logic [31:0]    imm;
        alu_op_e        alu_op;
        alu_a_src_e     alu_a_src;
        alu_b_src_e     alu_b_src;
        logic [1:0]     dmem_width;
        logic           dmem_zero_ext;
        logic           dmem_read;
        logic           dmem_write;
        jump_base_src_e jump_base_src;
        jump_cond_e     jump_cond;
        logic           rd_wen;
        rd_src_e        rd_src;
    } id_ex_ctrl_t;

    // alt is ins[30] already qualified by the caller (SUB only for OP, SRA for both).
    function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// Decode-stage bus: IF/ID instruction, writeback port, flush and the ID/EX register outputs.
interface rv32i_decode_stage_if;
    import rv32i_decode_stage_pkg::*;

    logic           pipe_flush;
    logic [31:0]    if_id__ins;
    logic           wb_id__rd_wen;
    logic [4:0]     wb_id__rd_addr;
    logic [31:0]    wb_id__rd_wdata;

    logic [31:0]    id_ex__rs1_rdata;
    logic [31:0]    id_ex__rs2_rdata;
    logic [4:0]     id_ex__rs1_addr;
    logic [4:0]     id_ex__rs2_addr;
    logic [4:0]     id_ex__rd_addr;
    logic [31:0]    id_ex__imm;
    alu_op_e        id_ex__alu_op;
    alu_a_src_e     id_ex__alu_a_src;
    alu_b_src_e     id_ex__alu_b_src;
    logic [1:0]     id_ex__dmem_width;
    logic           id_ex__dmem_zero_ext;
    logic           id_ex__dmem_read;
    logic           id_ex__dmem_write;
    jump_base_src_e id_ex__jump_base_src;
    jump_cond_e     id_ex__jump_cond;
    logic           id_ex__rd_wen;
    rd_src_e        id_ex__rd_src;

    modport master (
        output pipe_flush, if_id__ins, wb_id__rd_wen, wb_id__rd_addr, wb_id__rd_wdata,
        input  id_ex__rs1_rdata, id_ex__rs2_rdata, id_ex__rs1_addr, id_ex__rs2_addr, id_ex__rd_addr,
               id_ex__imm, id_ex__alu_op, id_ex__alu_a_src, id_ex__alu_b_src, id_ex__dmem_width,
               id_ex__dmem_zero_ext, id_ex__dmem_read, id_ex__dmem_write, id_ex__jump_base_src,
               id_ex__jump_cond, id_ex__rd_wen, id_ex__rd_src
    );

    modport slave (
        input  pipe_flush, if_id__ins, wb_id__rd_wen, wb_id__rd_addr, wb_id__rd_wdata,
        output id_ex__rs1_rdata, id_ex__rs2_rdata, id_ex__rs1_addr, id_ex__rs2_addr, id_ex__rd_addr,
               id_ex__imm, id_ex__alu_op, id_ex__alu_a_src, id_ex__alu_b_src, id_ex__dmem_width,
               id_ex__dmem_zero_ext, id_ex__dmem_read, id_ex__dmem_write, id_ex__jump_base_src,
               id_ex__jump_cond, id_ex__rd_wen, id_ex__rd_src
    );

endinterface

// File: rtl/rv32i_regfile.sv
// 32x32 register file, 2 read / 1 write, x0 hard-wired to zero.
// Reads see the value being written this cycle (write-through).
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_rdata,
    output logic [31:0] rs2_rdata,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (wen && (waddr != 5'd0)) regs_d[waddr] = wdata;
    end

    // Reading the next-state array gives write-through for free.
    assign rs1_rdata = (rs1_addr == 5'd0) ? 32'd0 : regs_d[rs1_addr];
    assign rs2_rdata = (rs2_addr == 5'd0) ? 32'd0 : regs_d[rs2_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: control decode, immediate generation and register read into the ID/EX register.
// An all-zero ID/EX register is the bubble: no writes, no memory access, COND_NEVER.
module rv32i_decode_stage
    import rv32i_decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rv32i_decode_stage_if.slave   bus
);

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_rdata_d, rs2_rdata_d, rs1_rdata_q, rs2_rdata_q;
    id_ex_ctrl_t id_ex_d, id_ex_q;

    assign ins    = bus.if_id__ins;
    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'd0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    rv32i_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr  (ins[19:15]),
        .rs2_addr  (ins[24:20]),
        .rs1_rdata (rs1_rdata_d),
        .rs2_rdata (rs2_rdata_d),
        .wen       (bus.wb_id__rd_wen),
        .waddr     (bus.wb_id__rd_addr),
        .wdata     (bus.wb_id__rd_wdata)
    );

    always_comb begin
        id_ex_d          = '0;
        id_ex_d.rs1_addr = ins[19:15];
        id_ex_d.rs2_addr = ins[24:20];
        id_ex_d.rd_addr  = ins[11:7];
        case (opcode)
            OPC_OP: begin
                id_ex_d.alu_op = alu_op_decode(funct3, ins[30]);
                id_ex_d.rd_wen = 1'b1;
            end
            OPC_OP_IMM: begin
                id_ex_d.alu_op    = alu_op_decode(funct3, ins[30] && (funct3 == 3'b101));
                id_ex_d.alu_b_src = B_IMM;
                id_ex_d.imm       = imm_i;
                id_ex_d.rd_wen    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                id_ex_d.alu_a_src = (opcode == OPC_LUI) ? A_ZERO : A_PC;
                id_ex_d.alu_b_src = B_IMM;
                id_ex_d.imm       = imm_u;
                id_ex_d.rd_wen    = 1'b1;
            end
            OPC_LOAD: begin
                id_ex_d.alu_b_src     = B_IMM;
                id_ex_d.imm           = imm_i;
                id_ex_d.dmem_read     = 1'b1;
                id_ex_d.dmem_width    = funct3[1:0];
                id_ex_d.dmem_zero_ext = funct3[2];
                id_ex_d.rd_wen        = 1'b1;
                id_ex_d.rd_src        = RD_DMEM;
            end
            OPC_STORE: begin
                id_ex_d.alu_b_src  = B_IMM;
                id_ex_d.imm        = imm_s;
                id_ex_d.dmem_write = 1'b1;
                id_ex_d.dmem_width = funct3[1:0];
            end
            OPC_JAL, OPC_JALR: begin
                id_ex_d.jump_cond     = COND_ALWAYS;
                id_ex_d.jump_base_src = (opcode == OPC_JAL) ? BASE_PC : BASE_RS1;
                id_ex_d.imm           = (opcode == OPC_JAL) ? imm_j : imm_i;
                id_ex_d.rd_wen        = 1'b1;
                id_ex_d.rd_src        = RD_PC4;
            end
            OPC_BRANCH: begin
                id_ex_d.imm = imm_b;
                // funct3[0] inverts the sense: BNE/BGE/BGEU vs BEQ/BLT/BLTU.
                case (funct3[2:1])
                    2'b00:   id_ex_d.alu_op = ALU_SUB;
                    2'b10:   id_ex_d.alu_op = ALU_SLT;
                    default: id_ex_d.alu_op = ALU_SLTU;
                endcase
                if (funct3[2]) id_ex_d.jump_cond = funct3[0] ? COND_ZERO : COND_NZERO;
                else           id_ex_d.jump_cond = funct3[0] ? COND_NZERO : COND_ZERO;
            end
            default: ;
        endcase
        if (ins[11:7] == 5'd0) id_ex_d.rd_wen = 1'b0;
        if (bus.pipe_flush) begin
            id_ex_d.rd_wen     = 1'b0;
            id_ex_d.dmem_read  = 1'b0;
            id_ex_d.dmem_write = 1'b0;
            id_ex_d.jump_cond  = COND_NEVER;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q     <= '0;
            rs1_rdata_q <= 32'd0;
            rs2_rdata_q <= 32'd0;
        end else begin
            id_ex_q     <= id_ex_d;
            rs1_rdata_q <= rs1_rdata_d;
            rs2_rdata_q <= rs2_rdata_d;
        end
    end

    assign bus.id_ex__rs1_rdata     = rs1_rdata_q;
    assign bus.id_ex__rs2_rdata     = rs2_rdata_q;
    assign bus.id_ex__rs1_addr      = id_ex_q.rs1_addr;
    assign bus.id_ex__rs2_addr      = id_ex_q.rs2_addr;
    assign bus.id_ex__rd_addr       = id_ex_q.rd_addr;
    assign bus.id_ex__imm           = id_ex_q.imm;
    assign bus.id_ex__alu_op        = id_ex_q.alu_op;
    assign bus.id_ex__alu_a_src     = id_ex_q.alu_a_src;
    assign bus.id_ex__alu_b_src     = id_ex_q.alu_b_src;
    assign bus.id_ex__dmem_width    = id_ex_q.dmem_width;
    assign bus.id_ex__dmem_zero_ext = id_ex_q.dmem_zero_ext;
    assign bus.id_ex__dmem_read     = id_ex_q.dmem_read;
    assign bus.id_ex__dmem_write    = id_ex_q.dmem_write;
    assign bus.id_ex__jump_base_src = id_ex_q.jump_base_src;
    assign bus.id_ex__jump_cond     = id_ex_q.jump_cond;
    assign bus.id_ex__rd_wen        = id_ex_q.rd_wen;
    assign bus.id_ex__rd_src        = id_ex_q.rd_src;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed bench for the RV32I decode stage; expected values are hand-decoded instruction fields.
module tb_rv32i_decode_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    rv32i_decode_stage_if bus();

    rv32i_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] ins, input logic flush);
        bus.if_id__ins = ins;
        bus.pipe_flush = flush;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.pipe_flush      = 1'b0;
        bus.if_id__ins      = 32'h0000_0013;
        bus.wb_id__rd_wen   = 1'b0;
        bus.wb_id__rd_addr  = 5'd0;
        bus.wb_id__rd_wdata = 32'd0;

        @(negedge clk);
        chk("rst_rd_wen",   32'(bus.id_ex__rd_wen), 32'd0);
        chk("rst_cond",     32'(bus.id_ex__jump_cond), 32'd0);
        chk("rst_dmem_rd",  32'(bus.id_ex__dmem_read), 32'd0);
        chk("rst_dmem_wr",  32'(bus.id_ex__dmem_write), 32'd0);
        chk("rst_imm",      bus.id_ex__imm, 32'd0);
        rst = 1'b0;

        drive(32'h0050_0093, 1'b0);                 // ADDI x1,x0,5
        tick();
        chk("addi_imm",     bus.id_ex__imm, 32'd5);
        chk("addi_rd",      32'(bus.id_ex__rd_addr), 32'd1);
        chk("addi_alu",     32'(bus.id_ex__alu_op), 32'd0);
        chk("addi_a",       32'(bus.id_ex__alu_a_src), 32'd0);
        chk("addi_b",       32'(bus.id_ex__alu_b_src), 32'd1);
        chk("addi_wen",     32'(bus.id_ex__rd_wen), 32'd1);
        chk("addi_rdsrc",   32'(bus.id_ex__rd_src), 32'd0);

        drive(32'h1234_5137, 1'b0);                 // LUI x2,0x12345
        tick();
        chk("lui_imm",      bus.id_ex__imm, 32'h1234_5000);
        chk("lui_a",        32'(bus.id_ex__alu_a_src), 32'd2);
        chk("lui_b",        32'(bus.id_ex__alu_b_src), 32'd1);
        chk("lui_wen",      32'(bus.id_ex__rd_wen), 32'd1);

        drive(32'h0000_1297, 1'b0);                 // AUIPC x5,1
        tick();
        chk("auipc_imm",    bus.id_ex__imm, 32'h0000_1000);
        chk("auipc_a",      32'(bus.id_ex__alu_a_src), 32'd1);

        drive(32'h0031_8233, 1'b0);                 // ADD x4,x3,x3 with x3 written this cycle
        bus.wb_id__rd_wen   = 1'b1;
        bus.wb_id__rd_addr  = 5'd3;
        bus.wb_id__rd_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wt_rs1",       bus.id_ex__rs1_rdata, 32'hDEAD_BEEF);
        chk("wt_rs2",       bus.id_ex__rs2_rdata, 32'hDEAD_BEEF);
        chk("add_rd",       32'(bus.id_ex__rd_addr), 32'd4);
        chk("add_b",        32'(bus.id_ex__alu_b_src), 32'd0);
        bus.wb_id__rd_wen = 1'b0;
        tick();
        chk("stored_rs1",   bus.id_ex__rs1_rdata, 32'hDEAD_BEEF);

        drive(32'h4020_82B3, 1'b0);                 // SUB x5,x1,x2
        tick();
        chk("sub_alu",      32'(bus.id_ex__alu_op), 32'd1);

        drive(32'h0000_0233, 1'b0);                 // ADD x4,x0,x0 while writing x0
        bus.wb_id__rd_wen   = 1'b1;
        bus.wb_id__rd_addr  = 5'd0;
        bus.wb_id__rd_wdata = 32'h1234_5678;
        tick();
        chk("x0_wt",        bus.id_ex__rs1_rdata, 32'd0);
        bus.wb_id__rd_wen = 1'b0;
        drive(32'h0000_0013, 1'b0);                 // ADDI x0,x0,0
        tick();
        chk("x0_read",      bus.id_ex__rs1_rdata, 32'd0);
        chk("rd0_wen",      32'(bus.id_ex__rd_wen), 32'd0);

        drive(32'hFE20_9CE3, 1'b0);                 // BNE x1,x2,-8
        tick();
        chk("bne_imm",      bus.id_ex__imm, 32'hFFFF_FFF8);
        chk("bne_alu",      32'(bus.id_ex__alu_op), 32'd1);
        chk("bne_cond",     32'(bus.id_ex__jump_cond), 32'd3);
        chk("bne_base",     32'(bus.id_ex__jump_base_src), 32'd0);
        chk("bne_wen",      32'(bus.id_ex__rd_wen), 32'd0);

        drive(32'h0020_D463, 1'b0);                 // BGE x1,x2,8
        tick();
        chk("bge_alu",      32'(bus.id_ex__alu_op), 32'd3);
        chk("bge_cond",     32'(bus.id_ex__jump_cond), 32'd2);
        chk("bge_imm",      bus.id_ex__imm, 32'd8);

        drive(32'h0030_C283, 1'b0);                 // LBU x5,3(x1)
        tick();
        chk("lbu_read",     32'(bus.id_ex__dmem_read), 32'd1);
        chk("lbu_width",    32'(bus.id_ex__dmem_width), 32'd0);
        chk("lbu_zext",     32'(bus.id_ex__dmem_zero_ext), 32'd1);
        chk("lbu_rdsrc",    32'(bus.id_ex__rd_src), 32'd2);
        chk("lbu_imm",      bus.id_ex__imm, 32'd3);

        drive(32'h0020_A223, 1'b0);                 // SW x2,4(x1)
        tick();
        chk("sw_write",     32'(bus.id_ex__dmem_write), 32'd1);
        chk("sw_width",     32'(bus.id_ex__dmem_width), 32'd2);
        chk("sw_imm",       bus.id_ex__imm, 32'd4);
        chk("sw_wen",       32'(bus.id_ex__rd_wen), 32'd0);

        drive(32'h0020_A223, 1'b1);                 // SW squashed by flush
        tick();
        chk("flush_sw_wr",  32'(bus.id_ex__dmem_write), 32'd0);
        chk("flush_sw_wen", 32'(bus.id_ex__rd_wen), 32'd0);
        chk("flush_sw_cnd", 32'(bus.id_ex__jump_cond), 32'd0);

        drive(32'h0080_00EF, 1'b0);                 // JAL x1,+8
        tick();
        chk("jal_imm",      bus.id_ex__imm, 32'd8);
        chk("jal_cond",     32'(bus.id_ex__jump_cond), 32'd1);
        chk("jal_base",     32'(bus.id_ex__jump_base_src), 32'd0);
        chk("jal_rdsrc",    32'(bus.id_ex__rd_src), 32'd1);

        drive(32'h0080_00EF, 1'b1);                 // JAL squashed by flush
        tick();
        chk("flush_jal_cnd", 32'(bus.id_ex__jump_cond), 32'd0);
        chk("flush_jal_wen", 32'(bus.id_ex__rd_wen), 32'd0);

        drive(32'h0003_00E7, 1'b0);                 // JALR x1,0(x6)
        tick();
        chk("jalr_cond",    32'(bus.id_ex__jump_cond), 32'd1);
        chk("jalr_base",    32'(bus.id_ex__jump_base_src), 32'd1);
        chk("jalr_rs1",     32'(bus.id_ex__rs1_addr), 32'd6);
        chk("jalr_wen",     32'(bus.id_ex__rd_wen), 32'd1);
        #2 rst = 1'b1;                              // mid-cycle, no clock edge
        #1;
        chk("arst_cond",    32'(bus.id_ex__jump_cond), 32'd0);
        chk("arst_base",    32'(bus.id_ex__jump_base_src), 32'd0);
        chk("arst_rdsrc",   32'(bus.id_ex__rd_src), 32'd0);
        chk("arst_wen",     32'(bus.id_ex__rd_wen), 32'd0);
        chk("arst_rs1",     32'(bus.id_ex__rs1_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0031_8233, 1'b0);                 // x3 must be cleared by reset
        tick();
        chk("rf_cleared",   bus.id_ex__rs1_rdata, 32'd0);

        drive(32'h4033_D393, 1'b0);                 // SRAI x7,x7,3
        tick();
        chk("srai_alu",     32'(bus.id_ex__alu_op), 32'd7);
        chk("srai_shamt",   32'(bus.id_ex__imm[4:0]), 32'd3);

        drive(32'h0033_D393, 1'b0);                 // SRLI x7,x7,3
        tick();
        chk("srli_alu",     32'(bus.id_ex__alu_op), 32'd6);

        drive(32'h4000_0093, 1'b0);                 // ADDI x1,x0,0x400 (ins[30]=1)
        tick();
        chk("addi30_alu",   32'(bus.id_ex__alu_op), 32'd0);
        chk("addi30_imm",   bus.id_ex__imm, 32'h0000_0400);

        drive(32'h0000_0073, 1'b0);                 // ECALL -> NOP
        tick();
        chk("sys_wen",      32'(bus.id_ex__rd_wen), 32'd0);
        chk("sys_cond",     32'(bus.id_ex__jump_cond), 32'd0);
        chk("sys_dmem",     32'({bus.id_ex__dmem_read, bus.id_ex__dmem_write}), 32'd0);
        chk("sys_alu",      32'(bus.id_ex__alu_op), 32'd0);
        chk("sys_bsrc",     32'(bus.id_ex__alu_b_src), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
